// File: rtl/noc_pkg.sv
// noc_pkg: flit width, field positions and field helpers shared across the NoC
package noc_pkg;
    localparam int FLIT_W  = 20;
    localparam int SRC_HI  = 15;
    localparam int SRC_LO  = 12;
    localparam int DSTC_HI = 7;
    localparam int DSTC_LO = 4;
    localparam int DST_HI  = 3;
    localparam int DST_LO  = 0;

    function automatic logic [3:0] flit_dest(input logic [FLIT_W-1:0] f);
        return f[DST_HI:DST_LO];
    endfunction
endpackage

// File: rtl/noc_sync_fifo.sv
// noc_sync_fifo: single-clock FIFO with flush, level and combinational head read
module noc_sync_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_din,
    output logic [W-1:0]             o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_lvl;

    // storage is write-only on push and deliberately left unreset
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr] <= i_din;
    end

    // pointers wrap naturally at the power-of-two depth; level tracks push minus pop
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_lvl <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (i_pop)  r_rd <= r_rd + 1'b1;
            r_lvl <= r_lvl + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end

    assign o_dout  = r_mem[r_rd];
    assign o_empty = (r_lvl == '0);
    assign o_full  = (r_lvl == (AW+1)'(DEPTH));
    assign o_level = r_lvl;
endmodule

// File: rtl/nic_inject_fifo.sv
// nic_inject_fifo: screens source flits into a FIFO feeding the router's local port
module nic_inject_fifo
    import noc_pkg::*;
#(
    parameter int         DEPTH   = 8,
    parameter logic [3:0] NODE_ID = 4'd0,
    parameter int         CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [FLIT_W-1:0]        in_flit,
    input  logic                     in_valid,
    input  logic                     flush,
    output logic [FLIT_W-1:0]        flit_out,
    output logic                     flit_valid,
    input  logic                     flit_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         acc_cnt,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [CNT_W-1:0]         sent_cnt
);
    logic             w_full;
    logic             w_empty;
    logic             w_ok;
    logic             w_live;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_fdrop;
    logic [CNT_W-1:0] r_acc;
    logic [CNT_W-1:0] r_drop;
    logic [CNT_W-1:0] r_sent;
    logic             r_ovf;

    assign w_ok    = (in_flit[DSTC_HI:DSTC_LO] == flit_dest(in_flit)) && (flit_dest(in_flit) != NODE_ID);
    assign w_live  = in_valid && !flush;
    assign w_pop   = !w_empty && flit_ready && !flush;
    assign w_push  = w_live && w_ok && (!w_full || w_pop);
    assign w_drop  = w_live && !w_push;
    assign w_fdrop = w_live && w_ok && w_full && !w_pop;

    noc_sync_fifo #(.W(FLIT_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (in_flit),
        .o_dout  (flit_out),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    // saturating statistics and the sticky full-drop flag; flush leaves them alone
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            r_drop <= '0;
            r_sent <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_acc  <= r_acc  + CNT_W'(w_push && !(&r_acc));
            r_drop <= r_drop + CNT_W'(w_drop && !(&r_drop));
            r_sent <= r_sent + CNT_W'(w_pop  && !(&r_sent));
            r_ovf  <= r_ovf | w_fdrop;
        end
    end

    assign flit_valid = !w_empty;
    assign overflow   = r_ovf;
    assign acc_cnt    = r_acc;
    assign drop_cnt   = r_drop;
    assign sent_cnt   = r_sent;
endmodule

// File: tb/tb_nic_inject_fifo.sv
// tb_nic_inject_fifo: directed and random stimulus against a queue-based reference model
module tb_nic_inject_fifo;
    localparam int         DEPTH = 8;
    localparam logic [3:0] NID   = 4'd7;
    localparam int         CW    = 8;
    localparam int         CMAX  = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [19:0] in_flit = '0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic [19:0] flit_out;
    logic        flit_valid;
    logic        flit_ready = 1'b0;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic [CW-1:0] acc_cnt, drop_cnt, sent_cnt;

    nic_inject_fifo #(.DEPTH(DEPTH), .NODE_ID(NID), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .flush(flush),
        .flit_out(flit_out), .flit_valid(flit_valid), .flit_ready(flit_ready),
        .fifo_level(fifo_level), .overflow(overflow),
        .acc_cnt(acc_cnt), .drop_cnt(drop_cnt), .sent_cnt(sent_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [19:0] m_q[$];
    int m_acc = 0, m_drop = 0, m_sent = 0;
    bit m_ovf = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [19:0] mk(input logic [3:0] d);
        return {8'h07, 4'h0, d, d};
    endfunction

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic step(input logic [19:0] f, input bit v, input bit rdy, input bit fl, input bit rs);
        bit ok, full, pop, push;
        rst = rs; flush = fl; in_flit = f; in_valid = v; flit_ready = rdy;
        if (rs) begin
            m_q.delete(); m_acc = 0; m_drop = 0; m_sent = 0; m_ovf = 0;
        end else if (!fl) begin
            ok   = (f[7:4] == f[3:0]) && (f[3:0] != NID);
            full = (m_q.size() == DEPTH);
            pop  = (m_q.size() > 0) && rdy;
            push = v && ok && (!full || pop);
            if (pop)  begin void'(m_q.pop_front()); m_sent = sat(m_sent + 1); end
            if (push) begin m_q.push_back(f); m_acc = sat(m_acc + 1); end
            if (v && !push) m_drop = sat(m_drop + 1);
            if (v && ok && full && !pop) m_ovf = 1;
        end else m_q.delete();
        @(posedge clk);
        #1;
        check("level", 32'(fifo_level), 32'(m_q.size()));
        check("valid", 32'(flit_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) check("flit_out", 32'(flit_out), 32'(m_q[0]));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("acc_cnt", 32'(acc_cnt), 32'(m_acc));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        check("sent_cnt", 32'(sent_cnt), 32'(m_sent));
        rst = 0; flush = 0; in_valid = 0;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step('0, 0, rdy, 0, 0);
    endtask

    initial begin
        logic [19:0] f;
        step('0, 0, 0, 0, 1);
        step('0, 0, 0, 0, 1);
        check("rst_valid", 32'(flit_valid), 32'd0);

        step(20'h070FF, 1, 1, 0, 0);
        check("basic_first", 32'(flit_out), 32'h070FF);
        step(20'h070EE, 1, 1, 0, 0);
        step(20'h07000, 1, 1, 0, 0);
        idle(2, 1);
        check("basic_acc", 32'(acc_cnt), 32'd3);
        check("basic_sent", 32'(sent_cnt), 32'd3);
        check("basic_drop", 32'(drop_cnt), 32'd0);

        step('0, 0, 0, 0, 1);
        step(20'h07077, 1, 1, 0, 0);
        step(20'h070F3, 1, 1, 0, 0);
        step(20'h07055, 1, 1, 0, 0);
        idle(2, 1);
        check("screen_drop", 32'(drop_cnt), 32'd2);
        check("screen_acc", 32'(acc_cnt), 32'd1);
        check("screen_ovf", 32'(overflow), 32'd0);

        step('0, 0, 0, 0, 1);
        for (int d = 0; d <= 10; d++) if (d != 7) step(mk(4'(d)), 1, 0, 0, 0);
        check("bp_level", 32'(fifo_level), 32'd8);
        check("bp_head", 32'(flit_out), 32'(mk(4'd0)));
        check("bp_drop", 32'(drop_cnt), 32'd2);
        check("bp_ovf", 32'(overflow), 32'd1);
        step(20'h07011, 1, 1, 0, 0);
        check("fullpp_level", 32'(fifo_level), 32'd8);
        check("fullpp_drop", 32'(drop_cnt), 32'd2);
        for (int i = 0; i < 7; i++) step('0, 0, 1, 0, 0);
        check("fullpp_last", 32'(flit_out), 32'h07011);
        idle(2, 1);
        check("drain_sent", 32'(sent_cnt), 32'd9);

        step('0, 0, 0, 0, 1);
        for (int i = 0; i < 6 * DEPTH; i++) begin
            f = mk(4'(8 + (i / 2) % 8));
            step(f, !i[0], i[0], 0, 0);
        end
        idle(DEPTH + 2, 1);
        check("wrap_drop", 32'(drop_cnt), 32'd0);
        check("wrap_acc", 32'(acc_cnt), 32'(3 * DEPTH));

        for (int d = 0; d <= 10; d++) if (d != 7) step(mk(4'(d)), 1, 0, 0, 0);
        step('0, 0, 0, 1, 0);
        check("flush_level", 32'(fifo_level), 32'd0);
        check("flush_ovf", 32'(overflow), 32'd1);
        for (int d = 1; d <= 5; d++) step(mk(4'(d)), 1, 0, 0, 0);
        step(mk(4'd9), 1, 1, 1, 0);
        check("flush2_level", 32'(fifo_level), 32'd0);
        for (int d = 1; d <= 3; d++) step(mk(4'(d)), 1, 0, 0, 0);
        step(mk(4'd4), 1, 1, 0, 1);
        check("rst_mid_valid", 32'(flit_valid), 32'd0);
        check("rst_mid_ovf", 32'(overflow), 32'd0);
        check("rst_mid_acc", 32'(acc_cnt), 32'd0);
        step(mk(4'd5), 1, 0, 0, 0);
        check("post_rst_head", 32'(flit_out), 32'(mk(4'd5)));

        for (int i = 0; i < 3000; i++) begin
            f = 20'($urandom);
            if ($urandom_range(0, 9) < 7) f[7:4] = f[3:0];
            step(f, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 99) < 2, $urandom_range(0, 999) < 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
